shift_issue_unit: RTL and testbench
===================================

# shift_issue_unit

Buffered issue stage directly upstream of the combinational `shiftRotate` datapath. Accepts shift/rotate requests through a valid/ready handshake, queues them in a small FIFO, and presents the head entry to `shiftRotate`. Captures the result in a registered output slot with its own valid/ready handshake. Supports chained requests, where the operand is the previous result instead of fresh data.

## Interface
- `DEPTH`, 4, request FIFO entries; power of two, ≥2
- `clk` input 1, rising-edge clock
- `rstN` input 1, asynchronous active-low reset
- `flush` input 1, synchronous clear of queue, output slot and chain register
- `inValid` input 1, request present
- `inReady` output 1, request accepted on `inValid && inReady`
- `inData` input 8, operand (ignored when `inChain`=1)
- `inCount` input 3, shift/rotate amount 0..7
- `inOp` input 2, operation: 00 SLL, 01 SRL, 10 ROL, 11 ROR
- `inChain` input 1, use last issued result as operand
- `outValid` output 1, result slot full
- `outReady` input 1, consumer takes result on `outValid && outReady`
- `outResult` output 8, registered shifter result
- `occupancy` output log2(DEPTH)+1, FIFO entries currently held

## Operation
- FIFO entry = {data[7:0], count[2:0], op[1:0], chain}.
- Push: on `inValid && inReady`. `inReady` = !full. There is no bypass; a full FIFO refuses input even when a pop occurs in the same cycle.
- Issue condition: FIFO non-empty && (!outValid || outReady).
- On issue:
  - Pop the head.
  - Load `outResult` with shiftRotate(operand, count, op).
  - Set `outValid`.
  - Update `lastResult` with the same value.
- Operand = head.chain ? `lastResult` : head.data.
- Chain resolution happens at issue time, not at push. Back-to-back chained entries therefore see each predecessor's result.
- Output handshake:
  - On `outValid && outReady` with no issue in the same cycle, clear `outValid`.
  - On handshake plus issue in the same cycle, `outValid` stays 1 with the new result (full throughput).
- Shifter semantics:
  - SLL/SRL zero-fill.
  - ROL/ROR rotate modulo 8.
  - Count 0 passes the operand unchanged for all ops.
- `flush`:
  - Empties the FIFO and clears `outValid`, `lastResult` and `occupancy`.
  - Takes priority over push, issue and output handshake in the same cycle.
  - `inReady` is forced low during the `flush` cycle.
- Reset (async, any time, including mid-operation):
  - `outValid`=0, `outResult`=0, `lastResult`=0, `occupancy`=0, `inReady`=1 after release.
  - Read/write pointers return to 0.
- Simultaneous push and issue: `occupancy` unchanged. Pointers wrap modulo DEPTH.
- Chain request with no prior result since reset/flush uses operand 0.

## Timing
- Latency: request accepted at edge k → `outValid`=1 after edge k+1, provided the slot is free.
- Throughput: one result per cycle while `outReady`=1 and the FIFO is non-empty.
- All outputs are registered except `inReady`, which is combinational from occupancy and `flush`.
- `outResult` holds stable while `outValid && !outReady`.
- A stalled consumer fills the FIFO after DEPTH further accepts; `inReady` drops the cycle `occupancy`=DEPTH.

## Structure
- Shared package `shift_pkg`:
  - op encoding constants `OP_SLL`=2'b00, `OP_SRL`=2'b01, `OP_ROL`=2'b10, `OP_ROR`=2'b11
  - data width 8 and count width 3
  - request-entry struct typedef
- One sub-module instance: `shiftRotate`, driven combinationally from the FIFO head and `lastResult` mux.
- FIFO implemented inline as an array plus pointers and a counter; no separate module.

## Test plan
- After reset, push {5, 2, SLL}, `outReady`=1 → `outValid` after 1 edge, `outResult`=20, `occupancy` returns 0.
- Push {100, 3, SRL}, then {134, 3, ROL}, then {134, 3, ROR} back-to-back → results 12, 52, 208 on consecutive cycles.
- Push {5, 2, SLL}, then chained {x, 3, SLL} → 20, then 160. A chain immediately after reset yields 0.
- Hold `outReady`=0 and push 5 requests:
  - 1 request moves to the output slot, 4 fill the FIFO, `inReady`=0, `outResult` stays stable.
  - Release `outReady` → all 5 results drain in order, one per cycle.
- With FIFO holding 3 entries and `outValid`=1, assert `flush` with `inValid`=1 → next cycle `occupancy`=0, `outValid`=0, request not accepted. A subsequent chain uses operand 0.
- Assert `rstN`=0 mid-drain (asynchronously, between edges) → outputs clear immediately. After release, {255, 0, ROR} → 255.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate issue stage: op encodings,
// datapath widths and the queued request entry.
package shift_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  count;
    logic [1:0]        op;
    logic              chain;
  } req_t;

endpackage

// File: rtl/shift_issue_unit_if.sv
// Request/result bus of the shift issue stage, plus its synchronous flush.
// Handshake: a request transfers on a rising edge where inValid && inReady;
// a result transfers on a rising edge where outValid && outReady. The sender
// holds its payload stable while valid is high and ready is low.
interface shift_issue_unit_if #(
  parameter int DEPTH = 4
);
  import shift_pkg::*;

  logic                    flush;
  logic                    inValid;
  logic                    inReady;
  logic [DATA_W-1:0]       inData;
  logic [CNT_W-1:0]        inCount;
  logic [1:0]              inOp;
  logic                    inChain;
  logic                    outValid;
  logic                    outReady;
  logic [DATA_W-1:0]       outResult;
  logic [$clog2(DEPTH):0]  occupancy;

  modport master (
    output flush, inValid, inData, inCount, inOp, inChain, outReady,
    input  inReady, outValid, outResult, occupancy
  );

  modport slave (
    input  flush, inValid, inData, inCount, inOp, inChain, outReady,
    output inReady, outValid, outResult, occupancy
  );

endinterface

// File: rtl/shift_issue_unit_shift_rotate.sv
// Combinational 8-bit shifter/rotator: zero-filling logical shifts and
// modulo-8 rotates; a count of 0 passes the operand through.
module shiftRotate
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] operand,
  input  logic [CNT_W-1:0]  count,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result
);

  logic [2*DATA_W-1:0] dbl;
  logic [2*DATA_W-1:0] rol_w;
  logic [2*DATA_W-1:0] ror_w;

  always_comb begin
    // Rotates shift a doubled copy so the wrapped bits fall into the kept byte.
    dbl    = {operand, operand};
    rol_w  = dbl << count;
    ror_w  = dbl >> count;
    result = operand;
    case (op)
      OP_SLL:  result = operand << count;
      OP_SRL:  result = operand >> count;
      OP_ROL:  result = rol_w[2*DATA_W-1:DATA_W];
      default: result = ror_w[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/shift_issue_unit.sv
// Buffered issue stage: queues shift/rotate requests in a small FIFO and
// issues the head into a registered result slot, resolving chains at issue.
module shift_issue_unit
  import shift_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstN,
  shift_issue_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  req_t              mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              out_valid;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] last_result;

  logic              full;
  logic              empty;
  logic              push;
  logic              issue;
  req_t              in_req;
  req_t              head;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] shift_res;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // No bypass: a full queue refuses input even if it pops this cycle.
  assign bus.inReady = !full && !bus.flush;
  assign push        = bus.inValid && !full && !bus.flush;
  assign issue       = !empty && (!out_valid || bus.outReady) && !bus.flush;

  assign in_req = '{data:  bus.inData,
                    count: bus.inCount,
                    op:    bus.inOp,
                    chain: bus.inChain};

  assign head    = mem[rd_ptr];
  assign operand = head.chain ? last_result : head.data;

  shiftRotate u_shift_rotate (
    .operand (operand),
    .count   (head.count),
    .op      (head.op),
    .result  (shift_res)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_req;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      last_result <= '0;
    end else if (bus.flush) begin
      // out_result is left as-is; out_valid already marks it as stale.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      last_result <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr      <= rd_ptr + 1'b1;
        out_result  <= shift_res;
        last_result <= shift_res;
        out_valid   <= 1'b1;
      end else if (out_valid && bus.outReady) begin
        out_valid <= 1'b0;
      end
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.outValid  = out_valid;
  assign bus.outResult = out_result;
  assign bus.occupancy = count;

endmodule

// File: tb/tb_shift_issue_unit.sv
// Bench for shift_issue_unit: directed scenarios then random traffic, all
// checked cycle by cycle against a queue-based behavioural model.
module tb_shift_issue_unit;
  import shift_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstN;

  always #5 clk = ~clk;

  shift_issue_unit_if #(.DEPTH(DEPTH)) bus ();

  shift_issue_unit #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  typedef struct {
    int d;
    int c;
    int op;
    bit ch;
  } m_req_t;

  m_req_t     mq[$];
  bit         m_ov;
  int         m_res;
  int         m_last;
  logic [7:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_shift(input int d, input int c, input int op);
    case (op)
      0:       return (d * (1 << c)) % 256;
      1:       return d / (1 << c);
      2:       return ((d * (1 << c)) % 256) + (d / (1 << (8 - c)));
      default: return (d / (1 << c)) + ((d * (1 << (8 - c))) % 256);
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ov   = 1'b0;
    m_res  = 0;
    m_last = 0;
  endtask

  // One clock: drive at negedge, check state, then advance the model at posedge.
  task automatic step(input bit v, input int d, input int c, input int op,
                      input bit ch, input bit ordy, input bit fl);
    bit     acc;
    bit     iss;
    bit     hs;
    m_req_t e;
    int     opnd;
    @(negedge clk);
    bus.inValid  = v;
    bus.inData   = d[7:0];
    bus.inCount  = c[2:0];
    bus.inOp     = op[1:0];
    bus.inChain  = ch;
    bus.outReady = ordy;
    bus.flush    = fl;
    #1;
    check("outValid", bus.outValid, m_ov);
    check("outResult", bus.outResult, m_res);
    check("occupancy", bus.occupancy, mq.size());
    check("inReady", bus.inReady, (mq.size() < DEPTH) && !fl);
    acc = v && (mq.size() < DEPTH) && !fl;
    iss = (mq.size() > 0) && (!m_ov || ordy) && !fl;
    hs  = m_ov && ordy && !fl;
    if (hs) begin
      check("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) check("sb_result", bus.outResult, exp_q.pop_front());
    end
    @(posedge clk);
    if (fl) begin
      mq.delete();
      exp_q.delete();
      m_ov   = 1'b0;
      m_last = 0;
    end else begin
      if (iss) begin
        e      = mq.pop_front();
        opnd   = e.ch ? m_last : e.d;
        m_res  = ref_shift(opnd, e.c, e.op);
        m_last = m_res;
        m_ov   = 1'b1;
        exp_q.push_back(m_res[7:0]);
      end else if (hs) begin
        m_ov = 1'b0;
      end
      if (acc) mq.push_back('{d: d, c: c, op: op, ch: ch});
    end
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 0, 0, 0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    rstN         = 1'b0;
    bus.flush    = 1'b0;
    bus.inValid  = 1'b0;
    bus.inData   = '0;
    bus.inCount  = '0;
    bus.inOp     = '0;
    bus.inChain  = 1'b0;
    bus.outReady = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;

    // Single request
    step(1'b1, 5, 2, OP_SLL, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    #1 check("t1_result", bus.outResult, 20);
    check("t1_occupancy", bus.occupancy, 0);
    idle(1'b1);

    // Back-to-back mixed ops
    step(1'b1, 100, 3, OP_SRL, 1'b0, 1'b1, 1'b0);
    step(1'b1, 134, 3, OP_ROL, 1'b0, 1'b1, 1'b0);
    #1 check("t2_srl", bus.outResult, 12);
    step(1'b1, 134, 3, OP_ROR, 1'b0, 1'b1, 1'b0);
    #1 check("t2_rol", bus.outResult, 52);
    idle(1'b1);
    #1 check("t2_ror", bus.outResult, 208);

    // Chained pair
    step(1'b1, 5, 2, OP_SLL, 1'b0, 1'b1, 1'b0);
    step(1'b1, 77, 3, OP_SLL, 1'b1, 1'b1, 1'b0);
    #1 check("t3_first", bus.outResult, 20);
    idle(1'b1);
    #1 check("t3_chain", bus.outResult, 160);
    idle(1'b1);

    // Stalled consumer fills the queue
    for (int i = 0; i < 5; i++) step(1'b1, 10 + 2 * i, 1, OP_SLL, 1'b0, 1'b0, 1'b0);
    #1 check("t4_inready_low", bus.inReady, 0);
    check("t4_occupancy", bus.occupancy, DEPTH);
    idle(1'b0);
    idle(1'b0);
    #1 check("t4_stable", bus.outResult, 20);
    repeat (7) idle(1'b1);

    // Flush with queue holding three and slot full
    for (int i = 0; i < 4; i++) step(1'b1, 30 + i, 1, OP_SRL, 1'b0, 1'b0, 1'b0);
    step(1'b1, 99, 1, OP_SLL, 1'b0, 1'b0, 1'b1);
    #1 check("t5_occupancy", bus.occupancy, 0);
    check("t5_outvalid", bus.outValid, 0);
    step(1'b1, 200, 2, OP_SLL, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    #1 check("t5_chain_zero", bus.outResult, 0);
    idle(1'b1);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) step(1'b1, 7 + i, 1, OP_ROL, 1'b0, 1'b1, 1'b0);
    #3 rstN = 1'b0;
    #1 check("t6_rst_outvalid", bus.outValid, 0);
    check("t6_rst_occupancy", bus.occupancy, 0);
    check("t6_rst_result", bus.outResult, 0);
    bus.inValid = 1'b0;
    model_reset();
    @(negedge clk);
    rstN = 1'b1;
    step(1'b1, 0, 3, OP_ROL, 1'b1, 1'b1, 1'b0);
    step(1'b1, 255, 0, OP_ROR, 1'b0, 1'b1, 1'b0);
    #1 check("t6_chain_after_reset", bus.outResult, 0);
    idle(1'b1);
    #1 check("t6_ror0", bus.outResult, 255);

    // Random traffic
    repeat (400) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0);
    end
    repeat (8) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
